uart_tx: RTL and testbench

UART transmitter, the transmit-direction counterpart of the UART RX path in the UART system. It accepts a parallel byte with a single-cycle valid strobe and serialises it onto TX_OUT. Frame format: start bit, DATA_WIDTH data bits LSB first, optional even/odd parity bit, one stop bit. CLK is the bit-rate clock (one bit per CLK cycle), supplied by the system clock divider.

---
 rtl/uart_tx_pkg.sv | 26 ++
 rtl/uart_tx_if.sv | 30 +++
 rtl/uart_tx_parity_calc.sv | 24 ++
 rtl/uart_tx.sv | 116 +++++++++++
 tb/tb_uart_tx.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_pkg
// Purpose  : Shared definitions for the UART transmit and receive paths:
//            FSM state encoding and parity type codes. Both ends import this
//            package so they use the same parity coding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

   // Frame sequencer states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   // Parity type codes carried on PAR_TYP
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_if
// Purpose  : Byte-in / serial-out bundle of the UART transmitter.
// Ports    : P_DATA, Data_Valid, PAR_EN, PAR_TYP  (driven by the byte source)
//            TX_OUT, busy                        (driven by the transmitter)
//            master modport = byte source, slave modport = transmitter
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  TX_OUT;
   logic                  busy;

   modport master (
      output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
      input  TX_OUT, busy
   );

   modport slave (
      input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
      output TX_OUT, busy
   );
endinterface : uart_tx_if
`default_nettype wire

// File: rtl/uart_tx_parity_calc.sv
`default_nettype none
// ============================================================================
// Module   : parity_calc
// Purpose  : Combinational parity generator over the latched frame data.
// Ports    : data_i     - latched data word
//            par_typ_i  - PAR_EVEN / PAR_ODD
//            par_bit_o  - parity bit to place on the line
// Revision : 1.0 - initial release
// ============================================================================
module parity_calc
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  par_typ_i,
   output logic                  par_bit_o
);

   // Even parity: bit makes the total number of ones even (XOR of data).
   assign par_bit_o = (par_typ_i == PAR_ODD) ? ~(^data_i) : (^data_i);

endmodule : parity_calc
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : UART transmitter. Latches a byte on Data_Valid while idle and
//            shifts out start bit, DATA_WIDTH data bits LSB first, optional
//            parity bit and one stop bit, one bit per CLK cycle.
// Ports    : CLK  - bit-rate clock, rising edge
//            RST  - asynchronous reset, active-low
//            bus  - uart_tx_if.slave (P_DATA, Data_Valid, PAR_EN, PAR_TYP in;
//                   TX_OUT, busy out, both registered)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic     CLK,
   input  logic     RST,
   uart_tx_if.slave bus
);

   localparam int                CNT_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   tx_state_e             state_q,   state_d;
   logic [CNT_W-1:0]      cnt_q,     cnt_d;
   logic [DATA_WIDTH-1:0] data_q,    data_d;
   logic                  par_en_q,  par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic                  tx_q,      tx_d;
   logic                  busy_q,    busy_d;
   logic                  par_bit;

   parity_calc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity_calc (
      .data_i    (data_q),
      .par_typ_i (par_typ_q),
      .par_bit_o (par_bit)
   );

   // Line outputs are registered from the current state, so each bit shows
   // up on TX_OUT one edge after the sequencer enters the matching state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      tx_d      = 1'b1;
      busy_d    = 1'b1;

      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (bus.Data_Valid) begin
               data_d    = bus.P_DATA;
               par_en_d  = bus.PAR_EN;
               par_typ_d = bus.PAR_TYP;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            tx_d    = 1'b0;
            cnt_d   = '0;
            state_d = ST_DATA;
         end
         ST_DATA: begin
            tx_d = data_q[cnt_q];
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = par_en_q ? ST_PARITY : ST_STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_PARITY: begin
            tx_d    = par_bit;
            state_d = ST_STOP;
         end
         ST_STOP: begin
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.TX_OUT = tx_q;
   assign bus.busy   = busy_q;

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx. Inputs are driven and outputs
//            sampled on the falling edge of CLK; expected line bits come from
//            fixed frame literals and from a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

   localparam int DW = 8;

   logic CLK = 1'b0;
   logic RST;
   int   checks = 0;
   int   errors = 0;

   always #5 CLK = ~CLK;

   uart_tx_if #(.DATA_WIDTH(DW)) tx_if ();

   uart_tx #(.DATA_WIDTH(DW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (tx_if)
   );

   // Reference model: k-th transmitted bit of a frame (k=0 is the start bit).
   function automatic logic ref_bit(logic [DW-1:0] d, logic pen, logic ptyp, int k);
      int   ones;
      logic par;
      ones = 0;
      for (int i = 0; i < DW; i++) ones += int'(d[i]);
      par = ((ones % 2) == 1) ? 1'b1 : 1'b0;   // even parity bit
      if (ptyp) par = ~par;
      if (k == 0) return 1'b0;
      if (k <= DW) return d[k-1];
      if (pen && k == DW + 1) return par;
      return 1'b1;
   endfunction

   function automatic int ref_len(logic pen);
      return DW + 2 + (pen ? 1 : 0);
   endfunction

   task automatic test_reset();
      RST              = 1'b0;
      tx_if.Data_Valid = 1'b0;
      tx_if.P_DATA     = '0;
      tx_if.PAR_EN     = 1'b0;
      tx_if.PAR_TYP    = 1'b0;
      repeat (3) @(negedge CLK);
      checks++;
      if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: tx=%b busy=%b expected tx=1 busy=0", tx_if.TX_OUT, tx_if.busy);
      end
      RST = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         checks++;
         if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle cyc%0d: tx=%b busy=%b expected tx=1 busy=0", c, tx_if.TX_OUT, tx_if.busy);
         end
      end
   endtask

   task automatic test_parity_frames();
      logic [7:0]  vdat [3] = '{8'hA5, 8'hA5, 8'h00};
      logic        vpen [3] = '{1'b1, 1'b1, 1'b0};
      logic        vtyp [3] = '{1'b0, 1'b1, 1'b0};
      logic [10:0] vseq [3] = '{11'h54A, 11'h74A, 11'h200};
      int          vlen [3] = '{11, 11, 10};
      for (int v = 0; v < 3; v++) begin
         int          bcnt;
         logic [10:0] exp;
         exp = vseq[v];
         @(negedge CLK);
         tx_if.P_DATA = vdat[v]; tx_if.PAR_EN = vpen[v]; tx_if.PAR_TYP = vtyp[v];
         tx_if.Data_Valid = 1'b1;
         @(negedge CLK);
         tx_if.Data_Valid = 1'b0;
         checks++;
         if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL frame%0d_latency: tx=%b busy=%b expected tx=1 busy=0", v, tx_if.TX_OUT, tx_if.busy);
         end
         bcnt = 0;
         for (int k = 0; k < vlen[v]; k++) begin
            @(negedge CLK);
            if (tx_if.busy === 1'b1) bcnt++;
            checks++;
            if (tx_if.TX_OUT !== exp[k]) begin
               errors++;
               $display("FAIL frame%0d_bit%0d: tx=%b expected %b", v, k, tx_if.TX_OUT, exp[k]);
            end
         end
         @(negedge CLK);
         checks++;
         if (bcnt != vlen[v] || tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL frame%0d_end: busy_cycles=%0d tx=%b busy=%b expected busy_cycles=%0d tx=1 busy=0",
                     v, bcnt, tx_if.TX_OUT, tx_if.busy, vlen[v]);
         end
      end
   endtask

   task automatic test_ignore_midframe();
      logic [10:0] exp;
      exp = 11'h54A;
      @(negedge CLK);
      tx_if.P_DATA = 8'hA5; tx_if.PAR_EN = 1'b1; tx_if.PAR_TYP = 1'b0;
      tx_if.Data_Valid = 1'b1;
      @(negedge CLK);
      tx_if.Data_Valid = 1'b0;
      for (int k = 0; k < 11; k++) begin
         @(negedge CLK);
         checks++;
         if (tx_if.TX_OUT !== exp[k] || tx_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL ignore_bit%0d: tx=%b busy=%b expected tx=%b busy=1", k, tx_if.TX_OUT, tx_if.busy, exp[k]);
         end
         if (k == 3) begin
            tx_if.P_DATA = 8'h3C; tx_if.PAR_TYP = 1'b1; tx_if.PAR_EN = 1'b0;
            tx_if.Data_Valid = 1'b1;
         end else begin
            tx_if.Data_Valid = 1'b0;
         end
         if (k == 6) tx_if.P_DATA = ~tx_if.P_DATA;
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         checks++;
         if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_second_frame cyc%0d: tx=%b busy=%b expected tx=1 busy=0", c, tx_if.TX_OUT, tx_if.busy);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic ex_tx, ex_busy;
      @(negedge CLK);
      tx_if.P_DATA = 8'h55; tx_if.PAR_EN = 1'b0; tx_if.PAR_TYP = 1'b0;
      tx_if.Data_Valid = 1'b1;
      @(negedge CLK);
      tx_if.P_DATA = 8'hFF;
      // Samples 0..9: frame 0x55, 10: single idle cycle, 11..20: frame 0xFF.
      for (int j = 0; j < 25; j++) begin
         @(negedge CLK);
         if (j < 10) begin
            ex_tx = ref_bit(8'h55, 1'b0, 1'b0, j); ex_busy = 1'b1;
         end else if (j == 10) begin
            ex_tx = 1'b1; ex_busy = 1'b0;
         end else if (j < 21) begin
            ex_tx = ref_bit(8'hFF, 1'b0, 1'b0, j - 11); ex_busy = 1'b1;
         end else begin
            ex_tx = 1'b1; ex_busy = 1'b0;
         end
         checks++;
         if (tx_if.TX_OUT !== ex_tx || tx_if.busy !== ex_busy) begin
            errors++;
            $display("FAIL b2b_sample%0d: tx=%b busy=%b expected tx=%b busy=%b",
                     j, tx_if.TX_OUT, tx_if.busy, ex_tx, ex_busy);
         end
         if (j == 10) tx_if.Data_Valid = 1'b0;
      end
   endtask

   task automatic test_reset_midframe();
      logic [9:0] exp;
      exp = 10'h302;   // 0x81, no parity
      @(negedge CLK);
      tx_if.P_DATA = 8'hA5; tx_if.PAR_EN = 1'b1; tx_if.PAR_TYP = 1'b0;
      tx_if.Data_Valid = 1'b1;
      @(negedge CLK);
      tx_if.Data_Valid = 1'b0;
      repeat (5) @(negedge CLK);   // now transmitting data bit 3 (a 0)
      #2 RST = 1'b0;
      #1;
      checks++;
      if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: tx=%b busy=%b expected tx=1 busy=0", tx_if.TX_OUT, tx_if.busy);
      end
      @(negedge CLK);
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      checks++;
      if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: tx=%b busy=%b expected tx=1 busy=0", tx_if.TX_OUT, tx_if.busy);
      end
      tx_if.P_DATA = 8'h81; tx_if.PAR_EN = 1'b0; tx_if.PAR_TYP = 1'b0;
      tx_if.Data_Valid = 1'b1;
      @(negedge CLK);
      tx_if.Data_Valid = 1'b0;
      for (int k = 0; k < 11; k++) begin
         @(negedge CLK);
         checks++;
         if (k < 10) begin
            if (tx_if.TX_OUT !== exp[k] || tx_if.busy !== 1'b1) begin
               errors++;
               $display("FAIL frame81_bit%0d: tx=%b busy=%b expected tx=%b busy=1", k, tx_if.TX_OUT, tx_if.busy, exp[k]);
            end
         end else if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL frame81_end: tx=%b busy=%b expected tx=1 busy=0", tx_if.TX_OUT, tx_if.busy);
         end
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 25; f++) begin
         logic [DW-1:0] d;
         logic          pen, ptyp;
         int            len, gap;
         d    = DW'($urandom);
         pen  = 1'($urandom);
         ptyp = 1'($urandom);
         len  = ref_len(pen);
         gap  = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) begin
            @(negedge CLK);
            checks++;
            if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
               errors++;
               $display("FAIL rand%0d_gap: tx=%b busy=%b expected tx=1 busy=0", f, tx_if.TX_OUT, tx_if.busy);
            end
         end
         tx_if.P_DATA = d; tx_if.PAR_EN = pen; tx_if.PAR_TYP = ptyp;
         tx_if.Data_Valid = 1'b1;
         @(negedge CLK);
         tx_if.Data_Valid = 1'b0;
         for (int k = 0; k < len; k++) begin
            @(negedge CLK);
            checks++;
            if (tx_if.TX_OUT !== ref_bit(d, pen, ptyp, k) || tx_if.busy !== 1'b1) begin
               errors++;
               $display("FAIL rand%0d_bit%0d: data=%h pen=%b typ=%b tx=%b busy=%b expected tx=%b busy=1",
                        f, k, d, pen, ptyp, tx_if.TX_OUT, tx_if.busy, ref_bit(d, pen, ptyp, k));
            end
            // Scramble inputs mid-frame; Data_Valid stays low near the frame end.
            tx_if.P_DATA     = DW'($urandom);
            tx_if.PAR_EN     = 1'($urandom);
            tx_if.PAR_TYP    = 1'($urandom);
            tx_if.Data_Valid = (k <= len - 3) ? 1'($urandom) : 1'b0;
         end
         @(negedge CLK);
         checks++;
         if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL rand%0d_end: tx=%b busy=%b expected tx=1 busy=0", f, tx_if.TX_OUT, tx_if.busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_parity_frames();
      test_ignore_midframe();
      test_back_to_back();
      test_reset_midframe();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_uart_tx
`default_nettype wire
